// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch controller: fetches one instruction over a req/valid
// handshake, issues it for one (possibly stalled) cycle, then resolves B/BR/HLT.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        ex_stall,
  input  logic [2:0]  flags,
  input  logic [15:0] rs_data,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        branch_taken,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;

  logic        flag_v, flag_n, flag_z;
  logic        cond_ok;
  logic [15:0] b_target;

  assign flag_v = flags[2];
  assign flag_n = flags[1];
  assign flag_z = flags[0];

  assign pc_plus2 = pc_q + 16'd2;
  // Word offset: sign-extended 9-bit immediate scaled by 2, added to pc+2.
  assign b_target = pc_plus2 + {{6{instr_q[8]}}, instr_q[8:0], 1'b0};

  always_comb begin
    cond_ok = 1'b0;
    case (instr_q[11:9])
      3'b000:  cond_ok = !flag_z;
      3'b001:  cond_ok = flag_z;
      3'b010:  cond_ok = !flag_z && !flag_n;
      3'b011:  cond_ok = flag_n;
      3'b100:  cond_ok = flag_z || !flag_n;
      3'b101:  cond_ok = flag_n || flag_z;
      3'b110:  cond_ok = flag_v;
      default: cond_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    branch_taken = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_valid) begin
          instr_d = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ex_stall) begin
          state_d = FETCH;
          pc_d    = pc_plus2;
          case (instr_q[15:12])
            OP_B: begin
              if (cond_ok) begin
                pc_d         = b_target;
                branch_taken = 1'b1;
              end
            end
            OP_BR: begin
              if (cond_ok) begin
                pc_d         = rs_data;
                branch_taken = 1'b1;
              end
            end
            OP_HLT: begin
              state_d = HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == EXEC);
  assign halted      = (state_q == HALT);
  assign pc          = pc_q;

endmodule
